// File: rtl/dma_pkg.sv
// Shared definitions for the DMA engine: FSM state encoding, register
// offsets within the I/O window and CTRL bit positions.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } dma_state_t;

    localparam logic [7:0] OFF_SRC_L   = 8'd0;
    localparam logic [7:0] OFF_SRC_H   = 8'd1;
    localparam logic [7:0] OFF_DST_L   = 8'd2;
    localparam logic [7:0] OFF_DST_H   = 8'd3;
    localparam logic [7:0] OFF_LEN     = 8'd4;
    localparam logic [7:0] OFF_CTRL    = 8'd5;
    localparam logic [7:0] WINDOW_SIZE = 8'd6;

    localparam int CTRL_START     = 0;
    localparam int CTRL_DONE_CLR  = 1;
    localparam int CTRL_SRC_FIXED = 2;
    localparam int CTRL_ABORT     = 3;

    // A programmed length of zero stands for a full 256-byte block.
    function automatic logic [8:0] len_to_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/dma_engine.sv
// Memory-to-memory DMA engine: six-register CPU I/O window plus a bus-master
// FSM that copies one byte every two clocks while granted.
module dma_engine
    import dma_pkg::*;
#(
    parameter logic [7:0] DMA_ADDRESS = 8'h18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic [7:0]  address,
    input  logic        w_en,
    input  logic        r_en,
    output logic [7:0]  dout,
    output logic        m_req,
    input  logic        m_gnt,
    output logic [15:0] m_address,
    output logic [7:0]  m_dout,
    output logic        m_w_en,
    output logic        m_r_en,
    input  logic [7:0]  m_din,
    output logic        done_flag,
    input  logic        done_flag_clr
);

    dma_state_t  state_q, state_d;
    logic [15:0] src_cfg_q, dst_cfg_q;
    logic [7:0]  len_q;
    logic        src_fixed_q;
    logic        done_flag_q, done_flag_d;
    logic [15:0] src_q, src_d, dst_q, dst_d;
    logic [8:0]  cnt_q, cnt_d;

    logic [7:0]  offset;
    logic        in_window, busy, cfg_wr, ctrl_wr, start, abort;

    assign offset    = address - DMA_ADDRESS;
    assign in_window = (offset < WINDOW_SIZE);
    assign busy      = (state_q == ST_REQ) || (state_q == ST_RD) || (state_q == ST_WR);
    assign cfg_wr    = w_en && in_window && !busy;
    assign ctrl_wr   = w_en && in_window && (offset == OFF_CTRL);
    assign start     = ctrl_wr && din[CTRL_START] && (state_q == ST_IDLE);
    assign abort     = ctrl_wr && din[CTRL_ABORT] && busy;
    assign done_flag = done_flag_q;

    // Entering DONE sets the flag even if an acknowledge arrives that cycle.
    always_comb begin
        done_flag_d = done_flag_q;
        if (state_q == ST_DONE) begin
            done_flag_d = 1'b1;
        end else if (done_flag_clr || (ctrl_wr && din[CTRL_DONE_CLR])) begin
            done_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            src_cfg_q   <= 16'h0000;
            dst_cfg_q   <= 16'h0000;
            len_q       <= 8'h00;
            src_fixed_q <= 1'b0;
            done_flag_q <= 1'b0;
        end else begin
            if (cfg_wr) begin
                case (offset)
                    OFF_SRC_L: src_cfg_q[7:0]  <= din;
                    OFF_SRC_H: src_cfg_q[15:8] <= din;
                    OFF_DST_L: dst_cfg_q[7:0]  <= din;
                    OFF_DST_H: dst_cfg_q[15:8] <= din;
                    OFF_LEN:   len_q           <= din;
                    OFF_CTRL:  src_fixed_q     <= din[CTRL_SRC_FIXED];
                    default:   ;
                endcase
            end
            done_flag_q <= done_flag_d;
        end
    end

    always_comb begin
        dout = 8'h00;
        if (r_en && in_window) begin
            case (offset)
                OFF_SRC_L: dout = src_cfg_q[7:0];
                OFF_SRC_H: dout = src_cfg_q[15:8];
                OFF_DST_L: dout = dst_cfg_q[7:0];
                OFF_DST_H: dout = dst_cfg_q[15:8];
                OFF_LEN:   dout = len_q;
                OFF_CTRL:  dout = {5'b00000, src_fixed_q, done_flag_q, busy};
                default:   dout = 8'h00;
            endcase
        end
    end

    // Strobes and master address are decoded straight from the state, so
    // they drop to zero the cycle after any reset or return to IDLE.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        m_req     = 1'b0;
        m_r_en    = 1'b0;
        m_w_en    = 1'b0;
        m_address = 16'h0000;
        m_dout    = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_REQ;
                    src_d   = src_cfg_q;
                    dst_d   = dst_cfg_q;
                    cnt_d   = len_to_count(len_q);
                end
            end
            ST_REQ: begin
                m_req = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (m_gnt) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                m_req     = 1'b1;
                m_r_en    = 1'b1;
                m_address = src_q;
                state_d   = abort ? ST_IDLE : ST_WR;
            end
            ST_WR: begin
                m_req     = 1'b1;
                m_w_en    = 1'b1;
                m_address = dst_q;
                m_dout    = m_din;
                dst_d     = dst_q + 16'd1;
                cnt_d     = cnt_q - 9'd1;
                if (!src_fixed_q) begin
                    src_d = src_q + 16'd1;
                end
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 9'd1) begin
                    state_d = ST_DONE;
                end else if (m_gnt) begin
                    state_d = ST_RD;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            src_q   <= 16'h0000;
            dst_q   <= 16'h0000;
            cnt_q   <= 9'd0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine: register table plus hand-built transfer
// sequences against a byte-addressed memory model and a strobe log.
module tb_dma_engine;
    import dma_pkg::*;

    localparam logic [7:0] BASE = 8'h18;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic [7:0]  address;
    logic        w_en;
    logic        r_en;
    logic [7:0]  dout;
    logic        m_req;
    logic        m_gnt;
    logic [15:0] m_address;
    logic [7:0]  m_dout;
    logic        m_w_en;
    logic        m_r_en;
    logic [7:0]  m_din = 8'h00;
    logic        done_flag;
    logic        done_flag_clr;

    always #5 clk = ~clk;

    dma_engine #(.DMA_ADDRESS(BASE)) dut (
        .clk(clk), .rst(rst), .din(din), .address(address), .w_en(w_en),
        .r_en(r_en), .dout(dout), .m_req(m_req), .m_gnt(m_gnt),
        .m_address(m_address), .m_dout(m_dout), .m_w_en(m_w_en),
        .m_r_en(m_r_en), .m_din(m_din), .done_flag(done_flag),
        .done_flag_clr(done_flag_clr)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } xact_t;

    typedef struct {
        logic       we;
        logic [7:0] waddr;
        logic [7:0] wdata;
        logic [7:0] raddr;
        logic [7:0] exp;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          inv_bad = 0;
    logic [7:0]  mem [0:65535];
    xact_t       wr_log[$];
    xact_t       rd_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-RAM model and bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (m_r_en) begin
            m_din <= mem[m_address];
            rd_log.push_back('{m_address, 8'h00, cyc});
        end
        if (m_w_en) begin
            wr_log.push_back('{m_address, m_dout, cyc});
        end
        if ((m_r_en && m_w_en) || (!m_r_en && !m_w_en && (m_address != 16'h0 || m_dout != 8'h0))) begin
            inv_bad++;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [7:0] data);
        address = addr;
        din     = data;
        w_en    = 1'b1;
        tick();
        w_en    = 1'b0;
        din     = 8'h00;
    endtask

    task automatic rd_reg(input logic [7:0] addr, output logic [7:0] data);
        address = addr;
        r_en    = 1'b1;
        #1;
        data    = dout;
        r_en    = 1'b0;
    endtask

    task automatic program_xfer(input logic [15:0] src, input logic [15:0] dst,
                                input logic [7:0] len, input logic [7:0] ctrl);
        wr_reg(BASE + OFF_SRC_L, src[7:0]);
        wr_reg(BASE + OFF_SRC_H, src[15:8]);
        wr_reg(BASE + OFF_DST_L, dst[7:0]);
        wr_reg(BASE + OFF_DST_H, dst[15:8]);
        wr_reg(BASE + OFF_LEN, len);
        wr_reg(BASE + OFF_CTRL, ctrl);
    endtask

    // Returns in the first cycle where BUSY reads 0 (the DONE cycle).
    task automatic wait_busy_low(input string name, input int budget);
        logic [7:0] s;
        int n = 0;
        rd_reg(BASE + OFF_CTRL, s);
        while (s[0] && n < budget) begin
            tick();
            n++;
            rd_reg(BASE + OFF_CTRL, s);
        end
        check({name, "_busy_clears"}, int'(s[0]), 0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        wait_busy_low(name, budget);
        tick();
        $display("xfer %s finished at cycle %0d", name, cyc);
    endtask

    vec_t        vecs[12];
    logic [7:0]  rd;
    logic [7:0]  t1_data [4];
    int          b, rb, n, bad;

    initial begin
        rst = 1'b0; w_en = 1'b0; r_en = 1'b0; din = 8'h00; address = 8'h00;
        m_gnt = 1'b0; done_flag_clr = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i[15:0]] = 8'(i * 7 + 3);
        t1_data = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) mem[16'h0100 + 16'(i)] = t1_data[i];

        repeat (3) tick();
        check("reset_outputs", int'({m_req, m_r_en, m_w_en, done_flag, m_address, m_dout}), 0);
        rst = 1'b1;
        tick();

        // Register window: write/readback, window edges, BUSY-free CTRL.
        vecs[0]  = '{1'b1, 8'h18, 8'h34, 8'h18, 8'h34};
        vecs[1]  = '{1'b1, 8'h19, 8'h12, 8'h19, 8'h12};
        vecs[2]  = '{1'b1, 8'h1A, 8'h78, 8'h1A, 8'h78};
        vecs[3]  = '{1'b1, 8'h1B, 8'h56, 8'h1B, 8'h56};
        vecs[4]  = '{1'b1, 8'h1C, 8'h09, 8'h1C, 8'h09};
        vecs[5]  = '{1'b0, 8'h00, 8'h00, 8'h1D, 8'h00};
        vecs[6]  = '{1'b0, 8'h00, 8'h00, 8'h17, 8'h00};
        vecs[7]  = '{1'b0, 8'h00, 8'h00, 8'h1E, 8'h00};
        vecs[8]  = '{1'b1, 8'h20, 8'hFF, 8'h18, 8'h34};
        vecs[9]  = '{1'b1, 8'h1D, 8'h04, 8'h1D, 8'h04};
        vecs[10] = '{1'b1, 8'h1D, 8'h00, 8'h1D, 8'h00};
        vecs[11] = '{1'b1, 8'h12, 8'hAB, 8'h1A, 8'h78};
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].we) wr_reg(vecs[i].waddr, vecs[i].wdata);
            rd_reg(vecs[i].raddr, rd);
            check($sformatf("vec%0d_rd_%0h", i, vecs[i].raddr), int'(rd), int'(vecs[i].exp));
        end
        address = BASE; r_en = 1'b0; #1;
        check("dout_no_ren", int'(dout), 0);

        // 4-byte copy with grant held.
        b = wr_log.size(); rb = rd_log.size();
        m_gnt = 1'b1;
        program_xfer(16'h0100, 16'h2000, 8'd4, 8'h01);
        wait_idle("t1", 100);
        check("t1_nwr", wr_log.size() - b, 4);
        check("t1_nrd", rd_log.size() - rb, 4);
        bad = 0;
        for (int i = 0; i < 4 && wr_log.size() - b == 4 && rd_log.size() - rb == 4; i++) begin
            if (wr_log[b+i].addr != 16'h2000 + 16'(i) || wr_log[b+i].data != t1_data[i] ||
                rd_log[rb+i].addr != 16'h0100 + 16'(i) || wr_log[b+i].cyc != rd_log[rb+i].cyc + 1)
                bad++;
        end
        check("t1_order", bad, 0);
        if (wr_log.size() - b == 4) check("t1_span", wr_log[b+3].cyc - rd_log[rb].cyc, 7);
        check("t1_done_flag", int'(done_flag), 1);
        rd_reg(BASE + OFF_CTRL, rd);
        check("t1_ctrl", int'(rd), 8'h02);

        // 256 bytes from a fixed source address.
        done_flag_clr = 1'b1; tick(); done_flag_clr = 1'b0;
        check("t2_clr", int'(done_flag), 0);
        mem[16'h0010] = 8'h5A;
        b = wr_log.size(); rb = rd_log.size();
        program_xfer(16'h0010, 16'h2000, 8'd0, 8'h05);
        wait_idle("t2", 1000);
        check("t2_nwr", wr_log.size() - b, 256);
        check("t2_nrd", rd_log.size() - rb, 256);
        bad = 0;
        for (int i = 0; i < 256 && wr_log.size() - b == 256 && rd_log.size() - rb == 256; i++) begin
            if (wr_log[b+i].addr != 16'h2000 + 16'(i) || wr_log[b+i].data != 8'h5A ||
                rd_log[rb+i].addr != 16'h0010)
                bad++;
        end
        check("t2_pattern", bad, 0);
        rd_reg(BASE + OFF_CTRL, rd);
        check("t2_ctrl", int'(rd), 8'h06);
        wr_reg(BASE + OFF_CTRL, 8'h02);
        rd_reg(BASE + OFF_CTRL, rd);
        check("t2_ctrl_clr", int'(rd), 8'h00);

        // Grant dropped during the second write for five cycles.
        for (int i = 0; i < 4; i++) mem[16'h0300 + 16'(i)] = 8'h11 * 8'(i + 1);
        b = wr_log.size(); rb = rd_log.size();
        m_gnt = 1'b1;
        program_xfer(16'h0300, 16'h3000, 8'd4, 8'h01);
        n = 0;
        while (!(m_w_en && wr_log.size() - b == 1) && n < 50) begin tick(); n++; end
        check("t3_found_wr2", int'(m_w_en), 1);
        m_gnt = 1'b0;
        bad = 0;
        wr_reg(BASE + OFF_SRC_L, 8'hEE);
        if (!(m_req && !m_r_en && !m_w_en)) bad++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!(m_req && !m_r_en && !m_w_en)) bad++;
        end
        check("t3_req_hold", bad, 0);
        rd_reg(BASE + OFF_SRC_L, rd);
        check("t3_busy_wr_ignored", int'(rd), 8'h00);
        m_gnt = 1'b1;
        wait_idle("t3", 100);
        check("t3_nwr", wr_log.size() - b, 4);
        bad = 0;
        for (int i = 0; i < 4 && wr_log.size() - b == 4; i++) begin
            if (wr_log[b+i].addr != 16'h3000 + 16'(i) || wr_log[b+i].data != 8'h11 * 8'(i + 1)) bad++;
        end
        check("t3_bytes", bad, 0);
        if (rd_log.size() - rb == 4) begin
            check("t3_resume_addr", int'(rd_log[rb+2].addr), 16'h0302);
            check("t3_resume_gap", rd_log[rb+2].cyc - wr_log[b+1].cyc, 6);
        end

        // Destination wraps through 0xFFFF.
        done_flag_clr = 1'b1; tick(); done_flag_clr = 1'b0;
        b = wr_log.size();
        program_xfer(16'h0400, 16'hFFFE, 8'd3, 8'h01);
        wait_idle("t4", 100);
        check("t4_nwr", wr_log.size() - b, 3);
        if (wr_log.size() - b == 3) begin
            check("t4_addr0", int'(wr_log[b].addr), 16'hFFFE);
            check("t4_addr1", int'(wr_log[b+1].addr), 16'hFFFF);
            check("t4_addr2", int'(wr_log[b+2].addr), 16'h0000);
        end

        // Abort during the second read.
        done_flag_clr = 1'b1; tick(); done_flag_clr = 1'b0;
        b = wr_log.size(); rb = rd_log.size();
        program_xfer(16'h0500, 16'h5000, 8'd4, 8'h01);
        n = 0;
        while (!(m_r_en && rd_log.size() - rb == 1) && n < 50) begin tick(); n++; end
        check("t5_found_rd2", int'(m_r_en), 1);
        wr_reg(BASE + OFF_CTRL, 8'h08);
        repeat (3) tick();
        check("t5_wr_skipped", wr_log.size() - b, 1);
        check("t5_nrd", rd_log.size() - rb, 2);
        rd_reg(BASE + OFF_CTRL, rd);
        check("t5_ctrl", int'(rd), 8'h00);
        check("t5_done_flag", int'(done_flag), 0);

        // Reset in the middle of a write.
        program_xfer(16'h0600, 16'h6000, 8'd4, 8'h01);
        n = 0;
        while (!m_w_en && n < 50) begin tick(); n++; end
        check("t6_found_wr", int'(m_w_en), 1);
        rst = 1'b0;
        tick();
        check("t6_outputs", int'({m_req, m_r_en, m_w_en, done_flag, m_address, m_dout}), 0);
        rst = 1'b1;
        b = wr_log.size(); rb = rd_log.size();
        repeat (4) tick();
        check("t6_no_strobes", (wr_log.size() - b) + (rd_log.size() - rb), 0);
        rd_reg(BASE + OFF_CTRL, rd);
        check("t6_ctrl", int'(rd), 8'h00);
        rd_reg(BASE + OFF_SRC_H, rd);
        check("t6_src_h", int'(rd), 8'h00);

        // Acknowledge coincident with DONE, then later clears.
        mem[16'h0700] = 8'h77;
        b = wr_log.size();
        program_xfer(16'h0700, 16'h7000, 8'd1, 8'h01);
        wait_busy_low("t7", 50);
        done_flag_clr = 1'b1; tick(); done_flag_clr = 1'b0;
        check("t7_set_wins", int'(done_flag), 1);
        if (wr_log.size() - b == 1) check("t7_data", int'(wr_log[b].data), 8'h77);
        done_flag_clr = 1'b1; tick(); done_flag_clr = 1'b0;
        check("t7_clr", int'(done_flag), 0);
        program_xfer(16'h0700, 16'h7100, 8'd1, 8'h01);
        wait_idle("t7b", 50);
        check("t7b_set", int'(done_flag), 1);
        wr_reg(BASE + OFF_CTRL, 8'h02);
        check("t7b_ctrl_clr", int'(done_flag), 0);

        check("bus_invariants", inv_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d required finish", cyc);
        $fatal(1, "global timeout");
    end

endmodule
